// File: rtl/reg_read_stage_if.sv
// Bundle of IF/ID, write-back and ID/EX signals around the register read stage.
//
// Signals:
//   if_id_valid/ir/type/pc  instruction presented by fetch
//   flush                   branch redirect, squashes the IF/ID instruction
//   wb_en/addr/data         register file write port from write-back
//   stall                   request to IF to hold PC and IF/ID
//   id_ex_*                 ID/EX pipeline register contents
//
// Modports:
//   slave   the register read stage
//   master  the surrounding pipeline (drives IF/ID and write-back)

interface reg_read_stage_if;
    logic        if_id_valid;
    logic [31:0] if_id_ir;
    logic [2:0]  if_id_type;
    logic [31:0] if_id_pc;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        id_ex_valid;
    logic [2:0]  id_ex_type;
    logic [31:0] id_ex_ir;
    logic [31:0] id_ex_pc;
    logic [31:0] id_ex_a;
    logic [31:0] id_ex_b;
    logic [31:0] id_ex_imm;

    modport slave (
        input  if_id_valid, if_id_ir, if_id_type, if_id_pc, flush,
        input  wb_en, wb_addr, wb_data,
        output stall, id_ex_valid, id_ex_type, id_ex_ir, id_ex_pc,
        output id_ex_a, id_ex_b, id_ex_imm
    );

    modport master (
        output if_id_valid, if_id_ir, if_id_type, if_id_pc, flush,
        output wb_en, wb_addr, wb_data,
        input  stall, id_ex_valid, id_ex_type, id_ex_ir, id_ex_pc,
        input  id_ex_a, id_ex_b, id_ex_imm
    );
endinterface

// File: rtl/reg_read_stage.sv
// Decode-side register read stage: 32 x 32-bit register file, operand read for the
// IF/ID instruction, ID/EX pipeline register and load-use hazard detection.
//
// Ports:
//   clk    pipeline clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    reg_read_stage_if.slave (IF/ID in, write-back in, stall and ID/EX out)
//
// Configuration macro:
//   WB_BYPASS_EN  defined: a write-back to a register being read in the same cycle is
//                 forwarded to the operand. Undefined: the read sees the old value and
//                 the instruction is stalled one cycle instead.

module reg_read_stage (
    input  logic            clk,
    input  logic            rst_n,
    reg_read_stage_if.slave bus
);

    localparam logic [2:0] TyNop    = 3'd0;
    localparam logic [2:0] TyRrAlu  = 3'd1;
    localparam logic [2:0] TyRmAlu  = 3'd2;
    localparam logic [2:0] TyLoad   = 3'd3;
    localparam logic [2:0] TyStore  = 3'd4;
    localparam logic [2:0] TyBranch = 3'd5;

    logic [31:0] rf_q [32];

    logic        id_ex_valid_q;
    logic [2:0]  id_ex_type_q;
    logic [31:0] id_ex_ir_q, id_ex_pc_q, id_ex_a_q, id_ex_b_q, id_ex_imm_q;

    logic [4:0]  rs, rt, load_dest;
    logic [2:0]  dec_type;
    logic        uses_rs, uses_rt;
    logic [31:0] rd_a, rd_b;
    logic        hazard_lu, hazard_wb, hazard;

    assign rs        = bus.if_id_ir[25:21];
    assign rt        = bus.if_id_ir[20:16];
    assign load_dest = id_ex_ir_q[20:16];

    // Types 6 and 7 decode as nop.
    assign dec_type = (bus.if_id_type > TyBranch) ? TyNop : bus.if_id_type;

    always_comb begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        case (dec_type)
            TyRrAlu, TyStore, TyBranch: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            TyRmAlu, TyLoad: uses_rs = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        rd_a = (rs == 5'd0) ? 32'd0 : rf_q[rs];
        rd_b = (rt == 5'd0) ? 32'd0 : rf_q[rt];
`ifdef WB_BYPASS_EN
        if (bus.wb_en && bus.wb_addr != 5'd0 && bus.wb_addr == rs) rd_a = bus.wb_data;
        if (bus.wb_en && bus.wb_addr != 5'd0 && bus.wb_addr == rt) rd_b = bus.wb_data;
`endif
    end

    assign hazard_lu = id_ex_valid_q && (id_ex_type_q == TyLoad) && (load_dest != 5'd0) &&
                       bus.if_id_valid &&
                       ((uses_rs && rs == load_dest) || (uses_rt && rt == load_dest));

`ifdef WB_BYPASS_EN
    assign hazard_wb = 1'b0;
`else
    // Without forwarding, retry once so the read sees the freshly written value.
    assign hazard_wb = bus.wb_en && (bus.wb_addr != 5'd0) && bus.if_id_valid &&
                       ((uses_rs && rs == bus.wb_addr) || (uses_rt && rt == bus.wb_addr));
`endif

    assign hazard    = hazard_lu || hazard_wb;
    assign bus.stall = hazard && !bus.flush;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (bus.wb_en && bus.wb_addr != 5'd0) begin
            rf_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_valid_q <= 1'b0;
            id_ex_type_q  <= 3'd0;
            id_ex_ir_q    <= 32'd0;
            id_ex_pc_q    <= 32'd0;
            id_ex_a_q     <= 32'd0;
            id_ex_b_q     <= 32'd0;
            id_ex_imm_q   <= 32'd0;
        end else if (bus.flush || hazard) begin
            id_ex_valid_q <= 1'b0;
            id_ex_type_q  <= 3'd0;
            id_ex_ir_q    <= 32'd0;
            id_ex_pc_q    <= 32'd0;
            id_ex_a_q     <= 32'd0;
            id_ex_b_q     <= 32'd0;
            id_ex_imm_q   <= 32'd0;
        end else begin
            id_ex_valid_q <= bus.if_id_valid;
            id_ex_type_q  <= dec_type;
            id_ex_ir_q    <= bus.if_id_ir;
            id_ex_pc_q    <= bus.if_id_pc;
            id_ex_a_q     <= rd_a;
            id_ex_b_q     <= rd_b;
            id_ex_imm_q   <= {{16{bus.if_id_ir[15]}}, bus.if_id_ir[15:0]};
        end
    end

    assign bus.id_ex_valid = id_ex_valid_q;
    assign bus.id_ex_type  = id_ex_type_q;
    assign bus.id_ex_ir    = id_ex_ir_q;
    assign bus.id_ex_pc    = id_ex_pc_q;
    assign bus.id_ex_a     = id_ex_a_q;
    assign bus.id_ex_b     = id_ex_b_q;
    assign bus.id_ex_imm   = id_ex_imm_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed bench for reg_read_stage: expected ID/EX contents are queued when an
// instruction is presented and compared one edge later.

module tb_reg_read_stage;

    typedef struct {
        logic        v;
        logic [2:0]  t;
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t bubble;

    reg_read_stage_if bus ();

    reg_read_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic v, input logic [2:0] t, input logic [31:0] ir,
                                input logic [31:0] pc, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] imm);
        exp_t e;
        e.v = v; e.t = t; e.ir = ir; e.pc = pc; e.a = a; e.b = b; e.imm = imm;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, bus.id_ex_valid}, 32'd0);
        chk({tag, "_type"}, {29'd0, bus.id_ex_type}, 32'd0);
        chk({tag, "_ir"}, bus.id_ex_ir, 32'd0);
        chk({tag, "_pc"}, bus.id_ex_pc, 32'd0);
        chk({tag, "_a"}, bus.id_ex_a, 32'd0);
        chk({tag, "_b"}, bus.id_ex_b, 32'd0);
        chk({tag, "_imm"}, bus.id_ex_imm, 32'd0);
        chk({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed empty scoreboard expected an entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, {31'd0, bus.id_ex_valid}, {31'd0, e.v});
            chk({tag, "_type"}, {29'd0, bus.id_ex_type}, {29'd0, e.t});
            chk({tag, "_ir"}, bus.id_ex_ir, e.ir);
            chk({tag, "_pc"}, bus.id_ex_pc, e.pc);
            chk({tag, "_a"}, bus.id_ex_a, e.a);
            chk({tag, "_b"}, bus.id_ex_b, e.b);
            chk({tag, "_imm"}, bus.id_ex_imm, e.imm);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] ir,
                         input logic [31:0] pc, input logic fl, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
        bus.if_id_valid = v;
        bus.if_id_type  = t;
        bus.if_id_ir    = ir;
        bus.if_id_pc    = pc;
        bus.flush       = fl;
        bus.wb_en       = we;
        bus.wb_addr     = wa;
        bus.wb_data     = wd;
    endtask

    // Called 1 time unit after a rising edge: present inputs, check stall, then check ID/EX.
    task automatic step(input string tag, input logic v, input logic [2:0] t,
                        input logic [31:0] ir, input logic [31:0] pc, input logic fl,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic st, input exp_t e);
        drive(v, t, ir, pc, fl, we, wa, wd);
        #1;
        chk({tag, "_stall"}, {31'd0, bus.stall}, {31'd0, st});
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bubble = mk(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        rst_n  = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        #2;
        chk_zero("reset");
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Register file writes with no instruction in IF/ID.
        step("wr_r7", 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, bubble);
        step("wr_r5", 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd5, 32'h0000_0055, 1'b0, bubble);
        step("wr_r3", 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd3, 32'h0000_3333, 1'b0, bubble);

        // rr_alu rs=7 rt=0 rd=1
        step("rd_r7", 1'b1, 3'd1, 32'h00E0_0800, 32'h100, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1'b1, 3'd1, 32'h00E0_0800, 32'h100, 32'hDEAD_BEEF, 32'd0, 32'h0000_0800));

        // Same-cycle write and read of r9 (rr_alu rs=9 rt=0 rd=2).
`ifdef WB_BYPASS_EN
        step("byp_r9", 1'b1, 3'd1, 32'h0120_1000, 32'h104, 1'b0, 1'b1, 5'd9, 32'h1234, 1'b0,
             mk(1'b1, 3'd1, 32'h0120_1000, 32'h104, 32'h1234, 32'd0, 32'h0000_1000));
`else
        step("wb_stall", 1'b1, 3'd1, 32'h0120_1000, 32'h104, 1'b0, 1'b1, 5'd9, 32'h1234, 1'b1,
             bubble);
        step("wb_retry", 1'b1, 3'd1, 32'h0120_1000, 32'h104, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1'b1, 3'd1, 32'h0120_1000, 32'h104, 32'h1234, 32'd0, 32'h0000_1000));
`endif

        // Load to r3 then rr_alu rs=0 rt=3 rd=4: one stall and bubble, then issue.
        step("ld_r3", 1'b1, 3'd3, 32'h0003_0004, 32'h200, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1'b1, 3'd3, 32'h0003_0004, 32'h200, 32'd0, 32'h3333, 32'h4));
        step("lu_stall", 1'b1, 3'd1, 32'h0003_2000, 32'h204, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1,
             bubble);
        step("lu_issue", 1'b1, 3'd1, 32'h0003_2000, 32'h204, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1'b1, 3'd1, 32'h0003_2000, 32'h204, 32'd0, 32'h3333, 32'h2000));

        // Same sequence targeting r0: no hazard.
        step("ld_r0", 1'b1, 3'd3, 32'h0000_0008, 32'h300, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1'b1, 3'd3, 32'h0000_0008, 32'h300, 32'd0, 32'd0, 32'h8));
        step("r0_nostall", 1'b1, 3'd1, 32'h0000_2800, 32'h304, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1'b1, 3'd1, 32'h0000_2800, 32'h304, 32'd0, 32'd0, 32'h2800));

        // Flush together with a load-use hazard: flush wins, no stall, bubble.
        step("ld_fl", 1'b1, 3'd3, 32'h0003_0010, 32'h400, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1'b1, 3'd3, 32'h0003_0010, 32'h400, 32'd0, 32'h3333, 32'h10));
        step("flush_lu", 1'b1, 3'd1, 32'h0003_2000, 32'h404, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0,
             bubble);

        // Write to r0 is discarded; rm_alu rs=0 rt=6 imm=0x8000 sign-extends.
        step("wr_r0", 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 32'h0000_FFFF, 1'b0, bubble);
        step("rm_imm", 1'b1, 3'd2, 32'h0006_8000, 32'h500, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1'b1, 3'd2, 32'h0006_8000, 32'h500, 32'd0, 32'd0, 32'hFFFF_8000));

        // Type 7 is loaded as type 0 with valid kept.
        step("type7", 1'b1, 3'd7, 32'h0000_0001, 32'h600, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1'b1, 3'd0, 32'h0000_0001, 32'h600, 32'd0, 32'd0, 32'h1));

        // Reset asserted mid-stall clears outputs and stall at once.
        step("ld_rst", 1'b1, 3'd3, 32'h0003_0004, 32'h700, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1'b1, 3'd3, 32'h0003_0004, 32'h700, 32'd0, 32'h3333, 32'h4));
        drive(1'b1, 3'd1, 32'h0003_2000, 32'h704, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("pre_rst_stall", {31'd0, bus.stall}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        @(posedge clk);
        #1;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // rr_alu rs=5 rt=7: both registers cleared by reset.
        step("post_rst", 1'b1, 3'd1, 32'h00A7_0000, 32'h800, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0,
             mk(1'b1, 3'd1, 32'h00A7_0000, 32'h800, 32'd0, 32'd0, 32'd0));

        chk("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

Decode-side register read stage of the five-stage pipeline; the read end of the register file that the write-back stage fills. Holds the 32 x 32-bit register file, takes the write port from write-back, reads both source operands for the instruction in IF/ID, and fills the ID/EX pipeline register. It detects load-use hazards against the instruction it issued in the previous cycle. On such a hazard it inserts a bubble and stalls fetch.

## Interface
Parameters:
- none (widths fixed: 32-bit data, 5-bit register index, 3-bit type)

Ports:
- clk  in  1  pipeline clock; every register updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_id_valid  in  1  IF/ID holds a real instruction
- if_id_ir  in  32  instruction word: rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0]
- if_id_type  in  3  instruction type: 0 nop, 1 rr_alu, 2 rm_alu, 3 load, 4 store, 5 branch; 6 and 7 are treated as nop
- if_id_pc  in  32  PC of the IF/ID instruction
- flush  in  1  branch redirect; squashes the IF/ID instruction
- wb_en  in  1  write-back write enable
- wb_addr  in  5  write-back destination register
- wb_data  in  32  write-back data
- stall  out  1  combinational; asks IF to hold PC and IF/ID
- id_ex_valid  out  1  ID/EX holds a real instruction
- id_ex_type  out  3  registered type
- id_ex_ir  out  32  registered instruction word
- id_ex_pc  out  32  registered PC
- id_ex_a  out  32  operand read from register rs
- id_ex_b  out  32  operand read from register rt
- id_ex_imm  out  32  sign-extended imm[15:0]

## Operation
- Register file: 32 entries. Register 0 always reads 0; writes to it are discarded. Write happens at the clk edge when wb_en=1.
- Sources used per type:
  - rr_alu, store, branch: rs and rt
  - rm_alu, load: rs only
  - nop: no sources
- Destination register written by each type: rr_alu writes rd; rm_alu and load write rt.
- Load-use hazard: all of the following hold:
  - id_ex_valid=1
  - id_ex_type=load
  - dest = id_ex_ir[20:16], dest != 0
  - dest equals a source used by the IF/ID instruction
  - if_id_valid=1
- stall = hazard AND NOT flush.
- Next-state priority, evaluated at each clk edge:
  1. flush=1: ID/EX receives a bubble.
  2. hazard: ID/EX receives a bubble.
  3. Otherwise ID/EX loads the decoded IF/ID instruction, with id_ex_valid = if_id_valid.
- Bubble contents: valid=0, type=0, ir=0, pc=0, a=0, b=0, imm=0.
- A type of 6 or 7 is loaded into ID/EX as type 0, with valid copied from IF/ID.

## Timing
- Reset: all 32 registers = 0 and every id_ex_* output = 0. stall is 0 because id_ex_valid=0. Reset takes effect immediately on rst_n low, independent of clk.
- Latency: IF/ID contents appear on id_ex_* one edge later.
- Write-to-read for the same register in the same cycle depends on the configuration (see Configuration).
- While stall=1, this stage issues bubbles. The upstream stage must keep IF/ID stable and re-present it.
- A load-use stall lasts exactly one cycle: the bubble clears id_ex_valid, so the hazard term is false on the next cycle.
- flush and hazard together: flush wins and stall=0.
- Reset asserted mid-stall: outputs clear at once, and the stall drops together with id_ex_valid.

## Configuration
- WB_BYPASS_EN defined:
  - A read of a nonzero register equal to wb_addr while wb_en=1 returns wb_data in the same cycle (write-before-read).
  - No extra stall.
- WB_BYPASS_EN undefined:
  - Reads return the pre-write register contents.
  - An extra stall term is added: wb_en=1, wb_addr != 0, and wb_addr equals a used source of a valid IF/ID instruction.
  - It causes one bubble cycle; on the retry the register holds the new value.
  - flush still has priority over this stall.

## Test plan
- Reset: drive rst_n low mid-cycle -> all id_ex_* = 0 and stall=0 immediately; a read of register 5 afterwards returns 0.
- Write then read: WB writes 0xDEADBEEF to r7. The next cycle presents rr_alu with rs=7, rt=0 -> id_ex_a=0xDEADBEEF, id_ex_b=0, id_ex_valid=1.
- Same-cycle write/read of r9 = 0x1234:
  - With WB_BYPASS_EN: id_ex_a=0x1234 with no stall.
  - Without WB_BYPASS_EN: one cycle with stall=1 and a bubble, then id_ex_a=0x1234.
- Load-use: load to r3, followed by rr_alu with rt=3 -> stall=1 for one cycle and one bubble, then the ALU instruction issues. The same sequence targeting r0 -> no stall.
- Flush during hazard: create the load-use case and assert flush in that same cycle -> stall=0 and the ID/EX bubble has id_ex_valid=0.
- Register 0 and immediate: write 0xFFFF to r0, then issue rm_alu with rs=0, imm=0x8000 -> id_ex_a=0, id_ex_imm=0xFFFF8000.
